hazard_scoreboard_unit: RTL

//  Next-generation forwarding/hazard unit for the 5-stage RISC-V pipeline with a non-pipelined multi-cycle multiplier.

---
 rtl/hazard_scoreboard_unit.sv | 99 +++++++++
 1 files changed

// File: rtl/hazard_scoreboard_unit.sv
// rtl/hazard_scoreboard_unit.sv - forwarding select, multiply scoreboard and stall logic (optional HAZ_PERF_CNT_EN stall counter)
module hazard_scoreboard_unit #(
    parameter int REG_AW  = 5,
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 3
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic [REG_AW-1:0] rs1_id,
    input  logic [REG_AW-1:0] rs2_id,
    input  logic [REG_AW-1:0] rd_id,
    input  logic              reg_write_id,
    input  logic              mul_id,
    input  logic [REG_AW-1:0] rs1_ex,
    input  logic [REG_AW-1:0] rs2_ex,
    input  logic [REG_AW-1:0] rd_ex,
    input  logic              mem_read_ex,
    input  logic              mul_ex,
    input  logic [REG_AW-1:0] rd_mem,
    input  logic              reg_write_mem,
    input  logic [REG_AW-1:0] rd_wb,
    input  logic              reg_write_wb,
    output logic [1:0]        forward_a,
    output logic [1:0]        forward_b,
    output logic              stall,
    output logic              mul_busy,
    output logic              mul_wr_en,
    output logic [REG_AW-1:0] mul_wr_rd
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cycles
`endif
);

    localparam logic [CNT_W-1:0]  LAT_C   = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [REG_AW-1:0] X0      = '0;

    logic [CNT_W-1:0]  cnt;
    logic [REG_AW-1:0] rd_q;

    logic load_use;
    logic mul_issue_raw;
    logic mul_pend_raw;
    logic mul_waw;
    logic mul_struct;

    // Operand source select; the younger EX/MEM result takes priority over MEM/WB
    always_comb begin
        forward_a = 2'b00;
        forward_b = 2'b00;
        if (reg_write_mem && rd_mem != X0 && rd_mem == rs1_ex)
            forward_a = 2'b10;
        else if (reg_write_wb && rd_wb != X0 && rd_wb == rs1_ex)
            forward_a = 2'b01;
        if (reg_write_mem && rd_mem != X0 && rd_mem == rs2_ex)
            forward_b = 2'b10;
        else if (reg_write_wb && rd_wb != X0 && rd_wb == rs2_ex)
            forward_b = 2'b01;
    end

    // Multiply scoreboard: load the countdown on issue, then count down to idle
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt  <= '0;
            rd_q <= '0;
        end else if (mul_ex) begin
            cnt  <= LAT_C;
            rd_q <= rd_ex;
        end else if (cnt != '0) begin
            cnt  <= cnt - CNT_ONE;
        end
    end

    assign mul_busy  = (cnt != '0);
    assign mul_wr_en = (cnt == CNT_ONE) && (rd_q != X0);
    assign mul_wr_rd = rd_q;

    // Hazard terms; the pending-RAW term stays up through the write cycle itself
    always_comb begin
        load_use      = mem_read_ex && rd_ex != X0 && (rd_ex == rs1_id || rd_ex == rs2_id);
        mul_issue_raw = mul_ex && rd_ex != X0 && (rd_ex == rs1_id || rd_ex == rs2_id);
        mul_pend_raw  = mul_busy && rd_q != X0 && (rd_q == rs1_id || rd_q == rs2_id);
        mul_waw       = mul_busy && reg_write_id && rd_id == rd_q && rd_q != X0;
        mul_struct    = mul_id && (mul_busy || mul_ex);
        stall         = load_use || mul_issue_raw || mul_pend_raw || mul_waw || mul_struct;
    end

`ifdef HAZ_PERF_CNT_EN
    // Saturating count of stalled cycles
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)
            stall_cycles <= '0;
        else if (stall && stall_cycles != 32'hFFFF_FFFF)
            stall_cycles <= stall_cycles + 32'd1;
    end
`endif

endmodule
